// File: rtl/ffn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ffn_ctrl_pkg
// Shared types and helpers for the FFN matrix-multiply sequencer.
//   ctrl_state_t  : sequencer state (IDLE / RUN / DRAIN)
//   sel_width()   : kernel-index width, never narrower than one bit
//   dl_payload_t  : one issue slot travelling down the datapath delay line
// -----------------------------------------------------------------------------
package ffn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Widest kernel index the payload can carry; the top uses the low SEL_W
    // bits. A fixed width keeps the struct usable from a package.
    localparam int IDX_W_MAX = 16;

    // $clog2(1) is 0, which would give a zero-width select bus.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 valid;  // read was issued in this slot
        logic                 first;  // address 0 of a kernel pass
        logic                 last;   // address ADDR_MAX of a kernel pass
        logic [IDX_W_MAX-1:0] idx;    // kernel / weight-RAM index
    } dl_payload_t;

endpackage : ffn_ctrl_pkg

// File: rtl/ffn_ctrl_delay_line.sv
// -----------------------------------------------------------------------------
// ffn_ctrl_delay_line
// Free-running DEPTH-stage shift register that aligns read-issue side-band
// information with the multiplier input.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-low; clears every stage
//   flush   : synchronous clear of every stage (run abort)
//   din     : payload of the slot issued this cycle
//   dout    : payload arriving at the multiplier (last stage)
//   pending : a valid slot sits in a stage other than the last, i.e. the line
//             will still present valid data after the next edge
// -----------------------------------------------------------------------------
module ffn_ctrl_delay_line
    import ffn_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  dl_payload_t din,
    output dl_payload_t dout,
    output logic        pending
);

    dl_payload_t stage [DEPTH];

    // NOTE: every stage is reset, not just the valid bits -- the stages feed
    // module outputs directly and must read 0 from reset onward.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its predecessor, so the loop order does not matter.
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage[i].valid;
        end
    end

endmodule : ffn_ctrl_delay_line

// File: rtl/ffn_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// ffn_matmul_seq_ctrl
// Sequencer for the fully-connected matrix-multiply datapath. Per run it walks
// feature-map addresses 0..ADDR_MAX once for each of K kernels, issuing read
// strobes, and produces multiplier/accumulator framing delayed by PIPE_LAT.
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   start            : begin a run (honoured in IDLE only, needs cfg != 0)
//   abort            : end the run at the next edge, flush the pipeline
//   stall            : do not issue a read in the next cycle
//   num_kernels_cfg  : kernels for this run, clamped to NUM_KERNELS
//   addr, ram_select : read address / weight-RAM index for rd_en
//   rd_en            : read strobe
//   mult_en          : multiplier operand valid (rd_en + PIPE_LAT)
//   acc_clear        : first beat of a kernel at the multiplier
//   kernel_done      : last beat of a kernel at the multiplier
//   kernel_idx       : kernel index accompanying mult_en
//   busy             : run in progress
//   product_rdy      : one-cycle pulse once every kernel has left the pipe
// -----------------------------------------------------------------------------
module ffn_matmul_seq_ctrl
    import ffn_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int ADDR_MAX    = 783,
    parameter int NUM_KERNELS = 10,
    parameter int SEL_W       = sel_width(NUM_KERNELS),
    parameter int PIPE_LAT    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [SEL_W:0]    num_kernels_cfg,
    output logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              rd_en,
    output logic              mult_en,
    output logic              acc_clear,
    output logic              kernel_done,
    output logic [SEL_W-1:0]  kernel_idx,
    output logic              busy,
    output logic              product_rdy
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);
    localparam logic [SEL_W:0]    K_MAX     = (SEL_W+1)'(NUM_KERNELS);

    ctrl_state_t       state;
    logic [SEL_W:0]    k_lat;       // kernels in the current run

    logic [ADDR_W-1:0] issue_addr;  // slot to present at the next edge
    logic [SEL_W-1:0]  issue_sel;
    logic              issue_last;  // that slot is the final one of the run
    logic [SEL_W:0]    k_new;
    logic              first_is_last;

    dl_payload_t       dl_in;
    dl_payload_t       dl_out;
    logic              dl_pending;

    // The addr/ram_select registers hold the slot currently on the bus. If it
    // was issued (rd_en=1) the next slot is its successor; if it was stalled it
    // is still owed and is presented again.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        issue_addr = addr;
        issue_sel  = ram_select;
        if (rd_en) begin
            if (addr == ADDR_LAST) begin
                issue_addr = '0;
                issue_sel  = ram_select + SEL_W'(1);
            end else begin
                issue_addr = addr + ADDR_W'(1);
            end
        end
        issue_last    = (issue_addr == ADDR_LAST) &&
                        ({1'b0, issue_sel} == k_lat - (SEL_W+1)'(1));
        k_new         = (num_kernels_cfg > K_MAX) ? K_MAX : num_kernels_cfg;
        // Degenerate single-beat run: ADDR_MAX=0 with one kernel.
        first_is_last = (ADDR_MAX == 0) && (k_new == (SEL_W+1)'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k_lat       <= '0;
            addr        <= '0;
            ram_select  <= '0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
            product_rdy <= 1'b0;
        end else if (abort) begin
            // Abort outranks start and every state; k_lat is left alone.
            state       <= IDLE;
            addr        <= '0;
            ram_select  <= '0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
            product_rdy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr        <= '0;
                    ram_select  <= '0;
                    rd_en       <= 1'b0;
                    product_rdy <= 1'b0;
                    if (start && (num_kernels_cfg != '0)) begin
                        k_lat <= k_new;
                        busy  <= 1'b1;
                        rd_en <= !stall;
                        state <= (!stall && first_is_last) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    addr       <= issue_addr;
                    ram_select <= issue_sel;
                    rd_en      <= !stall;
                    if (!stall && issue_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    addr       <= '0;
                    ram_select <= '0;
                    rd_en      <= 1'b0;
                    // The last read has left the issue register and no valid
                    // slot remains ahead of the final stage: the beat now at
                    // the multiplier is the run's last one.
                    if (!rd_en && !dl_pending) begin
                        product_rdy <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Side-band is zeroed on idle slots so kernel_idx reads 0 without mult_en.
    always_comb begin
        dl_in       = '0;
        dl_in.valid = rd_en;
        dl_in.first = rd_en && (addr == '0);
        dl_in.last  = rd_en && (addr == ADDR_LAST);
        dl_in.idx   = rd_en ? IDX_W_MAX'(ram_select) : '0;
    end

    ffn_ctrl_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clock   (clock),
        .reset   (reset),
        .flush   (abort),
        .din     (dl_in),
        .dout    (dl_out),
        .pending (dl_pending)
    );

    assign mult_en     = dl_out.valid;
    assign acc_clear   = dl_out.first;
    assign kernel_done = dl_out.last;
    assign kernel_idx  = dl_out.idx[SEL_W-1:0];

endmodule : ffn_matmul_seq_ctrl

// File: tb/tb_ffn_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ffn_matmul_seq_ctrl
// Self-checking bench: ADDR_MAX=3, NUM_KERNELS=4, PIPE_LAT=2. For each run the
// expected per-cycle trace is derived from the beat list of the run (beat b ->
// addr b%4, kernel b/4), the stall plan and the abort cycle. Cycle c is the
// cycle launched by the c-th rising edge after the start edge.
// -----------------------------------------------------------------------------
module tb_ffn_matmul_seq_ctrl;

    localparam int AW   = 4;
    localparam int AM   = 3;
    localparam int NK   = 4;
    localparam int SW   = 2;
    localparam int P    = 2;
    localparam int MAXC = 160;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall = 1'b0;
    logic [SW:0]   num_kernels_cfg = '0;
    logic [AW-1:0] addr;
    logic [SW-1:0] ram_select;
    logic          rd_en, mult_en, acc_clear, kernel_done, busy, product_rdy;
    logic [SW-1:0] kernel_idx;

    ffn_matmul_seq_ctrl #(
        .ADDR_W      (AW),
        .ADDR_MAX    (AM),
        .NUM_KERNELS (NK),
        .PIPE_LAT    (P)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .stall           (stall),
        .num_kernels_cfg (num_kernels_cfg),
        .addr            (addr),
        .ram_select      (ram_select),
        .rd_en           (rd_en),
        .mult_en         (mult_en),
        .acc_clear       (acc_clear),
        .kernel_done     (kernel_done),
        .kernel_idx      (kernel_idx),
        .busy            (busy),
        .product_rdy     (product_rdy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus plans indexed by cycle: stall/spurious start at the edge that
    // launches cycle c.
    bit stall_plan [MAXC];
    bit spur       [MAXC];

    // Expected trace.
    int e_rd [MAXC], e_addr [MAXC], e_sel [MAXC], e_busy [MAXC], e_prdy [MAXC];
    int e_mult [MAXC], e_clr [MAXC], e_kd [MAXC], e_kidx [MAXC];

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            stall_plan[c] = 1'b0;
            spur[c]       = 1'b0;
        end
    endtask

    task automatic rand_plan(input int stall_pct, input int n_spur);
        clear_plan();
        for (int c = 1; c < 60; c++) begin
            stall_plan[c] = ($urandom_range(0, 99) < stall_pct);
        end
        for (int i = 0; i < n_spur; i++) begin
            spur[$urandom_range(2, 30)] = 1'b1;
        end
    endtask

    // abort_at: -1 none, 0 together with start, >=1 at the edge launching that cycle.
    task automatic run_case(input string name, input int cfg_v, input int abort_at);
        int k, nb, b, t, len, hi;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_addr[c] = 0; e_sel[c] = 0; e_busy[c] = 0; e_prdy[c] = 0;
            e_mult[c] = 0; e_clr[c] = 0; e_kd[c] = 0; e_kidx[c] = 0;
        end
        k = (cfg_v > NK) ? NK : cfg_v;
        if (abort_at == 0) k = 0;
        nb = k * (AM + 1);
        b  = 0;
        t  = 0;
        if (k > 0) begin
            for (int c = 1; (b < nb) && (c < MAXC - 10); c++) begin
                e_busy[c] = 1;
                if (!stall_plan[c]) begin
                    e_rd[c]   = 1;
                    e_addr[c] = b % (AM + 1);
                    e_sel[c]  = b / (AM + 1);
                    b++;
                    if (b == nb) t = c;
                end else begin
                    e_addr[c] = b % (AM + 1);
                    e_sel[c]  = b / (AM + 1);
                end
            end
            for (int c = t + 1; c <= t + P; c++) e_busy[c] = 1;
            e_prdy[t + P + 1] = 1;
            for (int c = 1; c <= t; c++) begin
                if (e_rd[c] == 1) begin
                    e_mult[c + P] = 1;
                    e_clr[c + P]  = (e_addr[c] == 0) ? 1 : 0;
                    e_kd[c + P]   = (e_addr[c] == AM) ? 1 : 0;
                    e_kidx[c + P] = e_sel[c];
                end
            end
        end
        if (abort_at >= 1) begin
            for (int c = abort_at; c < MAXC; c++) begin
                e_rd[c] = 0; e_addr[c] = 0; e_sel[c] = 0; e_busy[c] = 0; e_prdy[c] = 0;
                e_mult[c] = 0; e_clr[c] = 0; e_kd[c] = 0; e_kidx[c] = 0;
            end
        end
        len = (k == 0) ? 4 : t + P + 4;
        if ((abort_at >= 1) && (abort_at + 3 < len)) len = abort_at + 3;
        // Spurious starts only where the sequencer is not idle.
        hi = (k == 0) ? 1 : t + P + 1;
        if ((abort_at >= 0) && (abort_at < hi)) hi = abort_at;
        for (int c = 0; c < MAXC; c++) begin
            if ((c < 2) || (c > hi)) spur[c] = 1'b0;
        end

        @(negedge clock);
        num_kernels_cfg = (SW+1)'(cfg_v);
        start = 1'b1;
        stall = stall_plan[1];
        abort = (abort_at == 0);
        for (int c = 1; c <= len; c++) begin
            @(negedge clock);
            check($sformatf("%s c%0d rd_en", name, c), 32'(rd_en), 32'(e_rd[c]));
            check($sformatf("%s c%0d addr", name, c), 32'(addr), 32'(e_addr[c]));
            check($sformatf("%s c%0d ram_select", name, c), 32'(ram_select), 32'(e_sel[c]));
            check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(e_busy[c]));
            check($sformatf("%s c%0d product_rdy", name, c), 32'(product_rdy), 32'(e_prdy[c]));
            check($sformatf("%s c%0d mult_en", name, c), 32'(mult_en), 32'(e_mult[c]));
            check($sformatf("%s c%0d acc_clear", name, c), 32'(acc_clear), 32'(e_clr[c]));
            check($sformatf("%s c%0d kernel_done", name, c), 32'(kernel_done), 32'(e_kd[c]));
            if (e_mult[c] == 1) begin
                check($sformatf("%s c%0d kernel_idx", name, c), 32'(kernel_idx), 32'(e_kidx[c]));
            end
            start = spur[c + 1];
            stall = stall_plan[c + 1];
            abort = (abort_at == c + 1);
            num_kernels_cfg = (SW+1)'($urandom_range(0, 7));
        end
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " addr"}, 32'(addr), 0);
        check({name, " ram_select"}, 32'(ram_select), 0);
        check({name, " rd_en"}, 32'(rd_en), 0);
        check({name, " mult_en"}, 32'(mult_en), 0);
        check({name, " acc_clear"}, 32'(acc_clear), 0);
        check({name, " kernel_done"}, 32'(kernel_done), 0);
        check({name, " kernel_idx"}, 32'(kernel_idx), 0);
        check({name, " busy"}, 32'(busy), 0);
        check({name, " product_rdy"}, 32'(product_rdy), 0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Directed scenarios.
        clear_plan();
        run_case("full", 4, -1);
        clear_plan();
        run_case("cfg2", 2, -1);
        clear_plan();
        run_case("cfg7", 7, -1);
        clear_plan();
        for (int c = 5; c <= 7; c++) stall_plan[c] = 1'b1;
        run_case("stall", 4, -1);
        clear_plan();
        run_case("abort", 4, 7);
        clear_plan();
        run_case("after_abort", 4, -1);
        clear_plan();
        spur[4]  = 1'b1;
        spur[17] = 1'b1;
        run_case("spur_start", 4, -1);
        clear_plan();
        run_case("cfg0", 0, -1);
        clear_plan();
        run_case("abort_with_start", 4, 0);
        clear_plan();
        run_case("abort_in_drain", 4, 18);

        // Asynchronous reset while draining.
        clear_plan();
        @(negedge clock);
        num_kernels_cfg = 3'd4;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (16) @(negedge clock);
        check("pre_reset busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check($sformatf("post_reset c%0d product_rdy", c), 32'(product_rdy), 0);
            check($sformatf("post_reset c%0d busy", c), 32'(busy), 0);
            check($sformatf("post_reset c%0d mult_en", c), 32'(mult_en), 0);
        end

        // Randomized runs.
        for (int i = 0; i < 40; i++) begin
            int cfg_v, ab;
            rand_plan($urandom_range(0, 35), $urandom_range(0, 3));
            cfg_v = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : -1;
            run_case($sformatf("rand%0d", i), cfg_v, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ffn_matmul_seq_ctrl

// File: doc/ffn_matmul_seq_ctrl.md
Name: ffn_matmul_seq_ctrl

Overview:
Parametrised sequencer for the fully-connected (FFN) matrix-multiply datapath. It walks the feature-map address range once per active kernel, selecting one weight RAM per pass, and issues read strobes. It also generates multiplier/accumulator control aligned to a configurable datapath latency. It adds what the earlier fixed controller lacked: a runtime kernel count, stall, abort, latency-compensated accumulator framing, and a busy/done handshake.

Parameters:
ADDR_W, 10, feature-map address width
ADDR_MAX, 783, last feature-map address per kernel pass (must be < 2**ADDR_W)
NUM_KERNELS, 10, number of weight RAMs / kernels
SEL_W, $clog2(NUM_KERNELS), kernel-index width (derived)
PIPE_LAT, 3, cycles from read issue to multiplier input valid (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
start  in  1  begin a run (sampled in IDLE only)
abort  in  1  terminate run immediately
stall  in  1  suppress issue this cycle
num_kernels_cfg  in  SEL_W+1  kernels to process this run (latched at start)
addr  out  ADDR_W  feature-map read address
ram_select  out  SEL_W  weight-RAM index (binary)
rd_en  out  1  read strobe for addr/ram_select
mult_en  out  1  multiplier operand valid (rd_en delayed PIPE_LAT)
acc_clear  out  1  first beat of a kernel at multiplier (delayed)
kernel_done  out  1  last beat of a kernel at multiplier (delayed)
kernel_idx  out  SEL_W  kernel index accompanying mult_en
busy  out  1  run in progress
product_rdy  out  1  one-cycle pulse: all kernels complete

Behaviour:
- All outputs registered. On reset: all outputs 0, state IDLE, pipeline flushed.
- States: IDLE, RUN, DRAIN.
- IDLE: addr=0, ram_select=0, rd_en=0. start=1 && abort=0 && cfg!=0 -> latch K=min(cfg,NUM_KERNELS), go RUN. start with cfg=0 is ignored.
- RUN: each cycle with stall=0: rd_en=1 with current addr/ram_select. addr increments; at ADDR_MAX it wraps to 0 and ram_select increments. Beat with addr==ADDR_MAX and ram_select==K-1 is the last issue -> DRAIN.
- RUN with stall=1: rd_en=0; addr/ram_select hold.
- DRAIN: waits until the delay line is empty; product_rdy=1 for exactly one cycle, then IDLE.
- Timing: start sampled at edge 0 -> first rd_en in cycle 1. Last issue in cycle T -> its mult_en/kernel_done in cycle T+PIPE_LAT -> product_rdy in cycle T+PIPE_LAT+1. busy=1 from cycle 1 through T+PIPE_LAT; busy=0 while product_rdy=1.
- Delay line is free-running (not stalled). It carries {rd_en, first=(addr==0), last=(addr==ADDR_MAX), ram_select} per issue slot.
- start while busy: ignored; latched K is unchanged.
- abort (any state): next cycle IDLE, busy=0, rd_en=0, delay line cleared, so mult_en is 0 from the next cycle. No product_rdy. abort beats start when both are asserted.
- ram_select never exceeds K-1; addr never exceeds ADDR_MAX.

Decomposition:
- Shared package ffn_ctrl_pkg: state enum (IDLE/RUN/DRAIN), clog2-width helper, delay-line payload struct {valid, first, last, idx}.
- One sub-module: ffn_ctrl_delay_line. PIPE_LAT-deep shift register of the payload with synchronous flush and asynchronous active-low reset.

Test Plan:
(All with ADDR_MAX=3, NUM_KERNELS=4, PIPE_LAT=2.)
1. cfg=4, start in cycle 0, no stall -> 16 rd_en beats in cycles 1-16; addr cycles 0,1,2,3; ram_select 0->3. acc_clear in cycles 3,7,11,15; kernel_done in 6,10,14,18; product_rdy only in cycle 19; busy 1-18.
2. cfg=2 -> 8 beats in cycles 1-8, ram_select max 1, product_rdy in cycle 11. cfg=7 -> clamped to 4, same as scenario 1.
3. Scenario 1 with stall=1 in cycles 5-7 -> addr/ram_select hold (addr=0, ram_select=1), rd_en=0 in those cycles; mult_en gap in cycles 7-9; product_rdy in cycle 22.
4. abort in cycle 6 -> cycle 7: busy=0, rd_en=0, mult_en=0, addr=0; product_rdy never asserts. A new start in cycle 8 runs a clean full sequence.
5. start pulses in cycles 4 and 17 during the run, plus cfg=0 start in IDLE -> no effect: sequence identical to scenario 1; cfg=0 leaves busy=0.
6. reset low in cycle 17 (DRAIN) -> all outputs 0 immediately (asynchronous); after release, IDLE with no product_rdy.
